// File: rtl/musicbox_pkg.sv
// Shared musicbox definitions: measurement FSM states and default
// counter width / timeout / deadband used by tone generators and meters.
package musicbox_pkg;

    localparam int          MB_CNT_W    = 16;
    localparam int unsigned MB_TIMEOUT  = 32'd65535;
    localparam int unsigned MB_DEADBAND = 32'd4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } meter_state_e;

endpackage

// File: rtl/tone_period_meter_if.sv
// Measurement result bus of tone_period_meter: the meter drives it (master),
// capture/display logic consumes it (slave).
interface tone_period_meter_if
    import musicbox_pkg::*;
#(
    parameter int CNT_W = MB_CNT_W
);
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             period_valid;
    logic             no_signal;
    logic             sweep_up;
    logic             sweep_down;

    modport master (
        output period, high_time, period_valid, no_signal, sweep_up, sweep_down
    );

    modport slave (
        input period, high_time, period_valid, no_signal, sweep_up, sweep_down
    );
endinterface

// File: rtl/audio_edge_sync.sv
// Two-flop synchronizer for an asynchronous musicbox input plus a third
// flop for single-cycle rise/fall pulses. All flops clear on reset.
module audio_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);
    logic [2:0] sync_q;
    logic [2:0] sync_d;

    // Next value of the synchronizer chain: shift din in at bit 0.
    always_comb begin
        sync_d = {sync_q[1:0], din};
    end

    // Synchronizer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rise = sync_q[1] & ~sync_q[2];
    assign fall = ~sync_q[1] & sync_q[2];
endmodule

// File: rtl/tone_period_meter.sv
// Measures period and high time of an asynchronous square wave, flags loss
// of signal and pitch sweep direction. Define PERIOD_AVG_EN for 4-period averaging.
module tone_period_meter
    import musicbox_pkg::*;
#(
    parameter int          CNT_W    = MB_CNT_W,
    parameter int unsigned TIMEOUT  = MB_TIMEOUT,
    parameter int unsigned DEADBAND = MB_DEADBAND
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                audio_in,
    tone_period_meter_if.master mif
);
    meter_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, hcnt_q, hcnt_d;
    logic [CNT_W-1:0] period_q, period_d, high_q, high_d, prev_q, prev_d;
    logic             valid_q, valid_d, no_sig_q, no_sig_d;
    logic             up_q, up_d, down_q, down_d, have_prev_q, have_prev_d;
    logic             rise_s, fall_s, emit_s;
    logic [CNT_W-1:0] rep_period_s, rep_high_s;
    logic [CNT_W:0]   new_ext_s, prev_ext_s, db_ext_s;

    audio_edge_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (audio_in),
        .rise  (rise_s),
        .fall  (fall_s)
    );

`ifdef PERIOD_AVG_EN
    // Sliding window holds the three periods/high times preceding the current one.
    logic [CNT_W-1:0] pwin_q [3];
    logic [CNT_W-1:0] hwin_q [3];
    logic [1:0]       fill_q, fill_d;
    logic [CNT_W+1:0] psum_s, hsum_s;

    // Window sum including the period being closed; report only once 4 are collected.
    always_comb begin
        psum_s = {2'b00, pwin_q[0]} + {2'b00, pwin_q[1]} + {2'b00, pwin_q[2]} + {2'b00, cnt_q};
        hsum_s = {2'b00, hwin_q[0]} + {2'b00, hwin_q[1]} + {2'b00, hwin_q[2]} + {2'b00, hcnt_q};
        rep_period_s = psum_s[CNT_W+1:2];
        rep_high_s   = hsum_s[CNT_W+1:2];
        emit_s       = (fill_q == 2'd3);
        fill_d       = fill_q;
        if ((state_q == IDLE) && rise_s) begin
            fill_d = 2'd0;
        end else if ((state_q == ARMED) && rise_s && (fill_q != 2'd3)) begin
            fill_d = fill_q + 2'd1;
        end else begin
            fill_d = fill_q;
        end
    end

    // Window shift on every completed period while armed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill_q <= 2'd0;
            pwin_q <= '{default: '0};
            hwin_q <= '{default: '0};
        end else begin
            fill_q <= fill_d;
            if ((state_q == ARMED) && rise_s) begin
                pwin_q <= '{pwin_q[1], pwin_q[2], cnt_q};
                hwin_q <= '{hwin_q[1], hwin_q[2], hcnt_q};
            end else begin
                pwin_q <= pwin_q;
                hwin_q <= hwin_q;
            end
        end
    end
`else
    // Raw mode reports every completed period directly.
    always_comb begin
        rep_period_s = cnt_q;
        rep_high_s   = hcnt_q;
        emit_s       = 1'b1;
    end
`endif

    assign new_ext_s  = {1'b0, rep_period_s};
    assign prev_ext_s = {1'b0, prev_q};
    assign db_ext_s   = (CNT_W+1)'(DEADBAND);

    // Measurement FSM: arming, counting, reporting and loss-of-signal timeout.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hcnt_d      = hcnt_q;
        period_d    = period_q;
        high_d      = high_q;
        prev_d      = prev_q;
        valid_d     = 1'b0;
        no_sig_d    = no_sig_q;
        up_d        = up_q;
        down_d      = down_q;
        have_prev_d = have_prev_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rise_s) begin
                    state_d     = ARMED;
                    cnt_d       = CNT_W'(1);
                    hcnt_d      = '0;
                    no_sig_d    = 1'b0;
                    have_prev_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            ARMED: begin
                if (rise_s) begin
                    cnt_d = CNT_W'(1);
                    if (emit_s) begin
                        period_d    = rep_period_s;
                        high_d      = rep_high_s;
                        valid_d     = 1'b1;
                        prev_d      = rep_period_s;
                        have_prev_d = 1'b1;
                        // Sweep compares against the previous report, one bit wider to avoid wrap.
                        if (have_prev_q && ((new_ext_s + db_ext_s) < prev_ext_s)) begin
                            up_d   = 1'b1;
                            down_d = 1'b0;
                        end else if (have_prev_q && (new_ext_s > (prev_ext_s + db_ext_s))) begin
                            up_d   = 1'b0;
                            down_d = 1'b1;
                        end else begin
                            up_d   = 1'b0;
                            down_d = 1'b0;
                        end
                    end else begin
                        valid_d = 1'b0;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    no_sig_d    = 1'b1;
                    up_d        = 1'b0;
                    down_d      = 1'b0;
                    have_prev_d = 1'b0;
                end else begin
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                    if (fall_s) begin
                        hcnt_d = cnt_q;
                    end else begin
                        hcnt_d = hcnt_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hcnt_q      <= '0;
            period_q    <= '0;
            high_q      <= '0;
            prev_q      <= '0;
            valid_q     <= 1'b0;
            no_sig_q    <= 1'b1;
            up_q        <= 1'b0;
            down_q      <= 1'b0;
            have_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hcnt_q      <= hcnt_d;
            period_q    <= period_d;
            high_q      <= high_d;
            prev_q      <= prev_d;
            valid_q     <= valid_d;
            no_sig_q    <= no_sig_d;
            up_q        <= up_d;
            down_q      <= down_d;
            have_prev_q <= have_prev_d;
        end
    end

    assign mif.period       = period_q;
    assign mif.high_time    = high_q;
    assign mif.period_valid = valid_q;
    assign mif.no_signal    = no_sig_q;
    assign mif.sweep_up     = up_q;
    assign mif.sweep_down   = down_q;
endmodule
